client_tx_framer: RTL
=====================

Name: client_tx_framer

Overview:
Downstream consumer of the client transmit unit; plays the Tx-port role opposite the client's req/length/ack/strobe/data_out handshake.
- Accepts one frame request at a time and issues ack, then a strobe burst to pull payload bytes.
- Wraps the payload in a GMII-style byte stream: preamble, SFD, payload, optional pad, FCS.
- Enforces inter-frame gap before accepting the next request. Single clock domain; output feeds the MAC/PHY byte interface.

Parameters:
jumbo_dw, 14, width of length port; max payload 2^jumbo_dw-1 bytes
IFG_CYCLES, 12, idle cycles with tx_en=0 after last FCS byte
MIN_PAYLOAD, 60, minimum payload+pad byte count (used only with pad feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  1  client frame request, held until ack
length  in  jumbo_dw  payload byte count, valid while req high
data_out  in  8  client payload byte, valid the cycle after its strobe
ack  out  1  one-cycle request acknowledge
strobe  out  1  payload byte pull, high exactly length cycles per frame
txd  out  8  transmit byte, registered
tx_en  out  1  transmit enable, registered
frame_count  out  16  completed frames, wraps at 2^16
err_zero_len  out  1  one-cycle pulse when a length-0 request is discarded

Behaviour:
- Reset: synchronous, active-high. Reset value of every output is 0: ack, strobe, txd, tx_en, frame_count, err_zero_len. State returns to IDLE. Reset mid-frame drops tx_en at the next edge; no FCS is emitted.
- States: IDLE, ACK, PRE, DATA, PAD, FCS, GAP.
- Timeline relative to cycle 0 (req sampled high in IDLE), with payload length L:
  - cycle 0: length latched.
  - cycle 1: ACK, ack=1.
  - cycles 2-8: PRE, txd=0x55, tx_en=1.
  - cycle 9: txd=0xD5 (SFD).
  - cycles 8..7+L: strobe=1.
  - cycles 9..8+L: data_out sampled.
  - cycles 10..9+L: DATA, txd=payload bytes, with no gaps.
  - then PAD (if enabled and needed), then 4 FCS cycles, then GAP for IFG_CYCLES cycles with tx_en=0, then IDLE.
- req is ignored outside IDLE. A new req may be sampled on the first IDLE cycle after GAP.
- length=0: ack pulses at cycle 1 and err_zero_len pulses at cycle 1. No strobe, no tx_en. Return to IDLE at cycle 2. frame_count unchanged.
- FCS (IEEE 802.3 CRC-32):
  - Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF.
  - Updated one byte per DATA/PAD cycle over payload and pad only; preamble and SFD are excluded.
  - Transmitted value is the complemented register, least-significant byte first.
- frame_count increments on the cycle of the last FCS byte.
- Payload counter is jumbo_dw bits wide; L = 2^jumbo_dw-1 must be handled without overflow.
- txd is 0 whenever tx_en=0.

Optional Feature:
CLIENT_TX_PAD_EN
- Defined: if L < MIN_PAYLOAD, PAD state emits MIN_PAYLOAD-L bytes of 0x00 after the payload. Pad bytes are included in the CRC; strobe is not asserted during PAD.
- Undefined: PAD state is absent. Short frames are sent unpadded, and FCS follows the payload directly.

Test Plan:
- L=9, payload ASCII "123456789": ack at cycle 1; strobe cycles 8-16; txd cycles 2-8 = 0x55 and cycle 9 = 0xD5. Without pad, FCS on cycles 19-22 = 0x26, 0x39, 0xF4, 0xCB. tx_en falls at cycle 23 and stays low for 12 cycles.
- Same frame with CLIENT_TX_PAD_EN: 51 bytes of 0x00 follow the payload (cycles 19-69). FCS matches a software CRC-32 over the 60 bytes. frame_count=1.
- Back-to-back: req held continuously with L=64. Second ack comes exactly 1+8+64+4+12+1 cycles after the first. strobe count per frame = 64.
- length=0: ack and err_zero_len pulse once; tx_en stays 0; frame_count unchanged; the next L=64 request is accepted normally.
- Reset asserted at payload byte 20 of an L=100 frame: next cycle tx_en=0, ack=0, strobe=0, frame_count=0. A fresh L=100 request then completes with a correct FCS.
- frame_count wrap: preload by running 65536 frames of L=1 (or force via bench); the counter reads 0 after the 65536th frame.

Source files
------------

// File: rtl/client_tx_if.sv
// client_tx_if: client request/strobe handshake plus the GMII-style byte output of the framer.
interface client_tx_if #(parameter int jumbo_dw = 14);
  logic                req;
  logic [jumbo_dw-1:0] length;
  logic [7:0]          data_out;
  logic                ack;
  logic                strobe;
  logic [7:0]          txd;
  logic                tx_en;
  logic [15:0]         frame_count;
  logic                err_zero_len;
  modport master (output req, length, data_out, input ack, strobe, txd, tx_en, frame_count, err_zero_len);
  modport slave (input req, length, data_out, output ack, strobe, txd, tx_en, frame_count, err_zero_len);
endinterface

// File: rtl/client_tx_framer.sv
// client_tx_framer: pulls client payload via ack/strobe and emits preamble, SFD, payload, pad, CRC-32 FCS, then IFG.
// Defining CLIENT_TX_PAD_EN zero-pads payloads shorter than MIN_PAYLOAD.
module client_tx_framer #(
  parameter int jumbo_dw    = 14,
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input logic        clk,
  input logic        rst,
  client_tx_if.slave cl_if
);
  typedef enum logic [2:0] {IDLE, ACK, PRE, DATA, PAD, FCS, GAP} state_e;
  state_e              state_q, state_d;
  logic [jumbo_dw-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [7:0]          txd_q, txd_d;
  logic                en_q, en_d;
  logic [31:0]         crc_q, crc_d, fcs;
  logic [15:0]         fc_q, fc_d;
  logic                need_pad;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
`ifdef CLIENT_TX_PAD_EN
  assign need_pad = len_q < jumbo_dw'(MIN_PAYLOAD);
`else
  assign need_pad = 1'b0;
`endif
  assign fcs = ~crc_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cl_if.req) begin
          state_d = ACK;
          len_d   = cl_if.length;
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? IDLE : PRE;
      end
      PRE: if (cnt_q == jumbo_dw'(7)) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      // cnt keeps running from DATA into PAD so PAD ends on the total byte count
      DATA: if (cnt_q == len_q - 1'b1) begin
        state_d = need_pad ? PAD : FCS;
        cnt_d   = need_pad ? cnt_q + 1'b1 : '0;
      end
      PAD: if (cnt_q == jumbo_dw'(MIN_PAYLOAD - 1)) begin
        state_d = FCS;
        cnt_d   = '0;
      end
      FCS: if (cnt_q == jumbo_dw'(3)) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == jumbo_dw'(IFG_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    en_d  = state_d inside {PRE, DATA, PAD, FCS};
    txd_d = state_d == PRE  ? (cnt_d == jumbo_dw'(7) ? 8'hD5 : 8'h55) :
            state_d == DATA ? cl_if.data_out :
            state_d == FCS  ? fcs[{cnt_d[1:0], 3'b000} +: 8] : 8'h00;
    crc_d = state_d inside {DATA, PAD} ? crc_byte(crc_q, txd_d) : state_d == FCS ? crc_q : '1;
    fc_d  = fc_q + {15'd0, state_q == FCS && cnt_q == jumbo_dw'(3)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      crc_q   <= '1;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      crc_q   <= crc_d;
      fc_q    <= fc_d;
    end
  end
  // strobe leads the matching txd byte by two cycles: last two PRE cycles, then all but the final two DATA cycles
  assign cl_if.strobe = (state_q == PRE && (cnt_q == jumbo_dw'(6) || (cnt_q == jumbo_dw'(7) && len_q > jumbo_dw'(1)))) ||
                        (state_q == DATA && ({1'b0, cnt_q} + (jumbo_dw + 1)'(2)) < {1'b0, len_q});
  assign cl_if.ack          = state_q == ACK;
  assign cl_if.err_zero_len = state_q == ACK && len_q == '0;
  assign cl_if.txd          = txd_q;
  assign cl_if.tx_en        = en_q;
  assign cl_if.frame_count  = fc_q;
endmodule
